// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator driven by the divided pixel clock.
// Free-running horizontal/vertical counters are decoded into sync, data-enable,
// pixel coordinates and line/frame start pulses. All outputs are registered,
// with one cycle of latency from the counter position they describe.
//
// Ports:
//   I_CLK          in   pixel clock, rising edge
//   Rst            in   asynchronous reset, active-low
//   En             in   pixel advance enable (tie 1 for free-running)
//   O_HS / O_VS    out  horizontal / vertical sync, active level = SYNC_POL
//   O_DE           out  active-video data enable
//   O_X / O_Y      out  pixel column / row while O_DE=1, else 0
//   O_LINE_START   out  one-cycle pulse at h=0 of every line
//   O_FRAME_START  out  one-cycle pulse at h=0, v=0
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned CW       = 11
) (
  input  logic          I_CLK,
  input  logic          Rst,
  input  logic          En,
  output logic          O_HS,
  output logic          O_VS,
  output logic          O_DE,
  output logic [CW-1:0] O_X,
  output logic [CW-1:0] O_Y,
  output logic          O_LINE_START,
  output logic          O_FRAME_START
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic        SYNC_ON      = 1'(SYNC_POL);
  localparam logic        SYNC_OFF     = ~SYNC_ON;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_last_c;
  logic          v_last_c;
  logic          de_c;
  logic          hs_c;
  logic          vs_c;
  logic          line_start_c;
  logic          frame_start_c;

  // Decode of the current counter position
  always_comb begin
    h_last_c      = (h_cnt == CW'(H_TOTAL - 1));
    v_last_c      = (v_cnt == CW'(V_TOTAL - 1));
    de_c          = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
    hs_c          = (h_cnt >= CW'(H_SYNC_START)) && (h_cnt < CW'(H_SYNC_END));
    vs_c          = (v_cnt >= CW'(V_SYNC_START)) && (v_cnt < CW'(V_SYNC_END));
    line_start_c  = (h_cnt == '0);
    frame_start_c = line_start_c && (v_cnt == '0);
  end

  // Horizontal/vertical position counters, advanced only on enabled edges
  always_ff @(posedge I_CLK or negedge Rst) begin
    if (!Rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (En) begin
      if (h_last_c) begin
        h_cnt <= '0;
        if (v_last_c) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + CW'(1);
        end
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  // Output registers: load the decode on enabled edges; pulses drop when stalled
  always_ff @(posedge I_CLK or negedge Rst) begin
    if (!Rst) begin
      O_HS          <= SYNC_OFF;
      O_VS          <= SYNC_OFF;
      O_DE          <= 1'b0;
      O_X           <= '0;
      O_Y           <= '0;
      O_LINE_START  <= 1'b0;
      O_FRAME_START <= 1'b0;
    end else if (En) begin
      O_HS          <= hs_c ? SYNC_ON : SYNC_OFF;
      O_VS          <= vs_c ? SYNC_ON : SYNC_OFF;
      O_DE          <= de_c;
      O_X           <= de_c ? h_cnt : '0;
      O_Y           <= de_c ? v_cnt : '0;
      O_LINE_START  <= line_start_c;
      O_FRAME_START <= frame_start_c;
    end else begin
      O_LINE_START  <= 1'b0;
      O_FRAME_START <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen. A default-parameter
// instance covers reset, line timing, enable gating and mid-frame reset; a
// small-parameter instance (14x7 raster, active-high syncs) covers the
// table-driven cycle-exact checks and whole-frame timing.
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_b, en_b;
  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [10:0] x_b, y_b;

  logic       rst_s, en_s;
  logic       hs_s, vs_s, de_s, ls_s, fs_s;
  logic [3:0] x_s, y_s;

  int n_chk;
  int n_fail;

  vga_timing_gen u_big (
    .I_CLK(clk), .Rst(rst_b), .En(en_b),
    .O_HS(hs_b), .O_VS(vs_b), .O_DE(de_b), .O_X(x_b), .O_Y(y_b),
    .O_LINE_START(ls_b), .O_FRAME_START(fs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1), .CW(4)
  ) u_small (
    .I_CLK(clk), .Rst(rst_s), .En(en_s),
    .O_HS(hs_s), .O_VS(vs_s), .O_DE(de_s), .O_X(x_s), .O_Y(y_s),
    .O_LINE_START(ls_s), .O_FRAME_START(fs_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic en;
    int   n;
    logic hs;
    logic vs;
    logic de;
    int   x;
    int   y;
    logic ls;
    logic fs;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic rst, logic en, int n, logic hs, logic vs,
                              logic de, int x, int y, logic ls, logic fs);
    vec_t v;
    v.rst = rst; v.en = en; v.n = n; v.hs = hs; v.vs = vs;
    v.de = de; v.x = x; v.y = y; v.ls = ls; v.fs = fs;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_b  = 1'b0; en_b = 1'b1;
    rst_s  = 1'b0; en_s = 1'b1;

    // ---------------- small instance: table-driven cycle checks ----------
    //            rst   en   n   hs vs de  x  y  ls fs
    tbl[0]  = mk(1'b0,1'b1, 2, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1'b1,1'b1, 1, 0, 0, 1, 0, 0, 1, 1);
    tbl[2]  = mk(1'b1,1'b1, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[3]  = mk(1'b1,1'b0, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[4]  = mk(1'b1,1'b0, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[5]  = mk(1'b1,1'b1, 1, 0, 0, 1, 2, 0, 0, 0);
    tbl[6]  = mk(1'b1,1'b1, 5, 0, 0, 1, 7, 0, 0, 0);
    tbl[7]  = mk(1'b1,1'b1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1'b1,1'b1, 2, 1, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1'b1,1'b1, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1'b1,1'b1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1'b1,1'b1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(1'b1,1'b1, 1, 0, 0, 1, 0, 1, 1, 0);
    tbl[13] = mk(1'b1,1'b0, 1, 0, 0, 1, 0, 1, 0, 0);
    tbl[14] = mk(1'b1,1'b1, 1, 0, 0, 1, 1, 1, 0, 0);
    tbl[15] = mk(1'b1,1'b1,34, 0, 0, 1, 7, 3, 0, 0);
    tbl[16] = mk(1'b1,1'b1, 6, 0, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(1'b1,1'b1, 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[18] = mk(1'b1,1'b1,14, 0, 1, 0, 0, 0, 1, 0);
    tbl[19] = mk(1'b1,1'b1,13, 0, 1, 0, 0, 0, 0, 0);
    tbl[20] = mk(1'b1,1'b1, 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[21] = mk(1'b1,1'b1,13, 0, 0, 0, 0, 0, 0, 0);
    tbl[22] = mk(1'b1,1'b1, 1, 0, 0, 1, 0, 0, 1, 1);

    for (int i = 0; i < 23; i++) begin
      rst_s = tbl[i].rst;
      en_s  = tbl[i].en;
      repeat (tbl[i].n) step();
      chk($sformatf("vec%0d_hs", i), int'(hs_s), int'(tbl[i].hs));
      chk($sformatf("vec%0d_vs", i), int'(vs_s), int'(tbl[i].vs));
      chk($sformatf("vec%0d_de", i), int'(de_s), int'(tbl[i].de));
      chk($sformatf("vec%0d_x",  i), int'(x_s),  tbl[i].x);
      chk($sformatf("vec%0d_y",  i), int'(y_s),  tbl[i].y);
      chk($sformatf("vec%0d_ls", i), int'(ls_s), int'(tbl[i].ls));
      chk($sformatf("vec%0d_fs", i), int'(fs_s), int'(tbl[i].fs));
    end

    // ---------------- small instance: whole-frame timing ----------------
    begin
      int fs_t[$];
      int de_n, hs_n, vs_n, max_x, max_y;
      de_n = 0; hs_n = 0; vs_n = 0; max_x = 0; max_y = 0;
      en_s = 1'b1;
      for (int t = 0; t < 294; t++) begin
        step();
        if (fs_s) fs_t.push_back(t);
        if (fs_t.size() == 1) begin
          if (de_s) de_n++;
          if (hs_s) hs_n++;
          if (vs_s) vs_n++;
          if (int'(x_s) > max_x) max_x = int'(x_s);
          if (int'(y_s) > max_y) max_y = int'(y_s);
        end
      end
      chk("small_fs_count", fs_t.size(), 3);
      if (fs_t.size() >= 2) chk("small_frame_period", fs_t[1] - fs_t[0], 98);
      chk("small_de_per_frame", de_n, 32);
      chk("small_hs_per_frame", hs_n, 14);
      chk("small_vs_per_frame", vs_n, 14);
      chk("small_max_x", max_x, 7);
      chk("small_max_y", max_y, 3);
    end

    // ---------------- big instance: reset values ------------------------
    repeat (3) step();
    chk("rst_hs", int'(hs_b), 1);
    chk("rst_vs", int'(vs_b), 1);
    chk("rst_de", int'(de_b), 0);
    chk("rst_x",  int'(x_b),  0);
    chk("rst_y",  int'(y_b),  0);
    chk("rst_ls", int'(ls_b), 0);
    chk("rst_fs", int'(fs_b), 0);

    // ---------------- big instance: first edge + line timing ------------
    rst_b = 1'b1;
    begin
      int ls_t[$];
      int de_n, hs_low, hs_fall, hs_rise;
      logic hs_prev;
      de_n = 0; hs_low = 0; hs_fall = -1; hs_rise = -1; hs_prev = 1'b1;
      for (int t = 0; t < 2400; t++) begin
        step();
        if (t == 0) begin
          chk("first_fs", int'(fs_b), 1);
          chk("first_ls", int'(ls_b), 1);
          chk("first_de", int'(de_b), 1);
          chk("first_x",  int'(x_b),  0);
          chk("first_y",  int'(y_b),  0);
        end
        if (t == 639) chk("line0_last_x", int'(x_b), 639);
        if (t == 640) chk("line0_blank_de", int'(de_b), 0);
        if (t == 805) chk("line1_y", int'(y_b), 1);
        if (ls_b) ls_t.push_back(t);
        if (de_b) de_n++;
        if (!hs_b) hs_low++;
        if (hs_prev && !hs_b && hs_fall < 0) hs_fall = t;
        if (!hs_prev && hs_b && hs_rise < 0) hs_rise = t;
        hs_prev = hs_b;
      end
      chk("ls_count", ls_t.size(), 3);
      if (ls_t.size() == 3) begin
        chk("ls_period0", ls_t[1] - ls_t[0], 800);
        chk("ls_period1", ls_t[2] - ls_t[1], 800);
      end
      chk("de_3lines", de_n, 1920);
      chk("hs_low_3lines", hs_low, 288);
      chk("hs_fall_offset", hs_fall, 656);
      chk("hs_low_width", hs_rise - hs_fall, 96);
    end

    // ---------------- big instance: En gating mid-line -------------------
    begin
      logic pat[4];
      int   en_edges, seen, frz_err, consec_err, p;
      logic p_hs, p_vs, p_de, p_ls;
      logic [10:0] p_x, p_y;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      en_b = 1'b1;
      repeat (300) step();
      en_edges = 0; seen = 0; frz_err = 0; consec_err = 0; p = 0;
      p_hs = hs_b; p_vs = vs_b; p_de = de_b; p_x = x_b; p_y = y_b; p_ls = ls_b;
      for (int c = 0; c < 6000 && seen < 2; c++) begin
        en_b = pat[p % 4];
        p++;
        step();
        if (!en_b) begin
          if (hs_b !== p_hs || vs_b !== p_vs || de_b !== p_de ||
              x_b !== p_x || y_b !== p_y || ls_b !== 1'b0 || fs_b !== 1'b0)
            frz_err++;
        end else if (seen == 1) begin
          en_edges++;
        end
        if (ls_b && p_ls) consec_err++;
        if (ls_b) seen++;
        p_hs = hs_b; p_vs = vs_b; p_de = de_b; p_x = x_b; p_y = y_b; p_ls = ls_b;
      end
      en_b = 1'b1;
      chk("gate_two_lines_seen", seen, 2);
      chk("gate_line_en_edges", en_edges, 800);
      chk("gate_frozen_errors", frz_err, 0);
      chk("gate_ls_consecutive", consec_err, 0);
    end

    // ---------------- big instance: reset mid-frame ----------------------
    begin
      int found;
      found = 0;
      for (int c = 0; c < 4000 && found == 0; c++) begin
        step();
        if (de_b && int'(x_b) == 300) found = 1;
      end
      chk("mid_found_x300", found, 1);
      chk("mid_y_nonzero", int'(y_b != 11'd0), 1);
      rst_b = 1'b0;
      #1;
      chk("mid_async_de", int'(de_b), 0);
      chk("mid_async_x",  int'(x_b),  0);
      chk("mid_async_y",  int'(y_b),  0);
      chk("mid_async_hs", int'(hs_b), 1);
      chk("mid_async_vs", int'(vs_b), 1);
      repeat (3) step();
      chk("mid_hold_de", int'(de_b), 0);
      chk("mid_hold_ls", int'(ls_b), 0);
      rst_b = 1'b1;
      step();
      chk("mid_restart_fs", int'(fs_b), 1);
      chk("mid_restart_de", int'(de_b), 1);
      chk("mid_restart_x",  int'(x_b),  0);
      chk("mid_restart_y",  int'(y_b),  0);
      step();
      chk("mid_next_x",  int'(x_b),  1);
      chk("mid_next_fs", int'(fs_b), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
